// File: rtl/burst_ram_initiator.sv
// burst_ram_initiator: initiator side of the BurstRAM command/burst protocol.
// It turns one whole-line client request into one BurstRAM command plus
// BURST_COUNT data beats. Read beats are packed into a line, which is returned
// with a single-cycle rsp_valid pulse.
// Optional feature: define BURST_RAM_INITIATOR_TIMEOUT_EN to add a read
// watchdog (TIMEOUT_CYCLES) and the rsp_err output.
module burst_ram_initiator #(
    parameter int DATA_BITWIDTH  = 64,
    parameter int DEPTH_BITWIDTH = 8,
    parameter int BURST_COUNT    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic                                          req_write,
    input  logic [DEPTH_BITWIDTH-$clog2(BURST_COUNT)-1:0] req_line,
    input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]          req_wr_data,
    input  logic [(DATA_BITWIDTH/8)*BURST_COUNT-1:0]      req_wr_mask,
    output logic                                          rsp_valid,
    output logic [DATA_BITWIDTH*BURST_COUNT-1:0]          rsp_rd_data,
    output logic                                          br_cmd,
    output logic                                          br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]                     br_addr,
    output logic [DATA_BITWIDTH-1:0]                      br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]                    br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]                      br_rd_data,
    input  logic                                          br_rd_data_valid,
    input  logic                                          br_busy
`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
    ,
    output logic                                          rsp_err
`endif
);

    localparam int CNT_W  = $clog2(BURST_COUNT);
    localparam int LINE_W = DEPTH_BITWIDTH - CNT_W;
    localparam int MASK_W = DATA_BITWIDTH / 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_COUNT - 1);

    // Reject parameter sets the datapath cannot represent.
    generate
        if ((DATA_BITWIDTH % 8) != 0 || BURST_COUNT < 2 ||
            (BURST_COUNT & (BURST_COUNT - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("burst_ram_initiator: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WR_BEATS,
        RD_COLLECT,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               write_reg;
    logic [LINE_W-1:0]  line_reg;

    // Per-beat views of the request and of the stored lines.
    logic [DATA_BITWIDTH-1:0] req_beat      [BURST_COUNT];
    logic [MASK_W-1:0]        req_mask_beat [BURST_COUNT];
    logic [DATA_BITWIDTH-1:0] wr_beat_reg   [BURST_COUNT];
    logic [MASK_W-1:0]        wr_mask_reg   [BURST_COUNT];
    logic [DATA_BITWIDTH-1:0] collect_reg   [BURST_COUNT];
    logic [DATA_BITWIDTH-1:0] rsp_slot_reg  [BURST_COUNT];

    logic             accept;
    logic             cmd_fire;
    logic             beat_store;
    logic             last_store;
    logic             timeout_hit;
    logic             wr_beat_active;
    logic [CNT_W-1:0] beat_idx;

    generate
        for (genvar gi = 0; gi < BURST_COUNT; gi++) begin : g_beats
            assign req_beat[gi]      = req_wr_data[gi*DATA_BITWIDTH +: DATA_BITWIDTH];
            assign req_mask_beat[gi] = req_wr_mask[gi*MASK_W +: MASK_W];
            assign rsp_rd_data[gi*DATA_BITWIDTH +: DATA_BITWIDTH] = rsp_slot_reg[gi];
        end
    endgenerate

    // Ready only in IDLE and never while reset is held, so it reads 0 during
    // reset and rises together with rst_n.
    assign req_ready  = (state_reg == IDLE) && rst_n;
    assign accept     = req_valid && req_ready;
    assign cmd_fire   = (state_reg == ISSUE) && !br_busy;
    assign beat_store = (state_reg == RD_COLLECT) && br_rd_data_valid;
    assign last_store = beat_store && (cnt_reg == LAST_BEAT);

`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_reg;
    logic             err_reg;

    // A beat arriving in the same cycle as the limit wins over the timeout.
    assign timeout_hit = (state_reg == RD_COLLECT) && !br_rd_data_valid &&
                         (tmo_reg == TMO_W'(TIMEOUT_CYCLES));
    assign rsp_err     = (state_reg == DONE) && err_reg;

    // Watchdog: counts idle RD_COLLECT cycles, restarted by every read beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (cmd_fire || beat_store) begin
                tmo_reg <= '0;
            end else if (state_reg == RD_COLLECT && tmo_reg != TMO_W'(TIMEOUT_CYCLES)) begin
                tmo_reg <= tmo_reg + 1'b1;
            end
            if (accept) begin
                err_reg <= 1'b0;
            end else if (timeout_hit) begin
                err_reg <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State, beat counter and the registered command fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            write_reg <= 1'b0;
            line_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                write_reg <= req_write;
                line_reg  <= req_line;
            end
        end
    end

    // Write line and mask captured on acceptance so the client is free next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BURST_COUNT; i++) begin
                wr_beat_reg[i] <= '0;
                wr_mask_reg[i] <= '0;
            end
        end else if (accept) begin
            wr_beat_reg <= req_beat;
            wr_mask_reg <= req_mask_beat;
        end
    end

    // Read assembly. The scratch line starts as a copy of the last response,
    // so slots missed by a timed-out read keep their previous values, and the
    // visible response only changes when a read finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BURST_COUNT; i++) begin
                collect_reg[i]  <= '0;
                rsp_slot_reg[i] <= '0;
            end
        end else begin
            if (cmd_fire && !write_reg) begin
                collect_reg <= rsp_slot_reg;
            end else if (beat_store) begin
                collect_reg[cnt_reg] <= br_rd_data;
            end
            if (last_store) begin
                for (int i = 0; i < BURST_COUNT - 1; i++) begin
                    rsp_slot_reg[i] <= collect_reg[i];
                end
                rsp_slot_reg[BURST_COUNT-1] <= br_rd_data;
            end else if (timeout_hit) begin
                rsp_slot_reg <= collect_reg;
            end
        end
    end

    // Next-state and beat-counter logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                    cnt_next   = '0;
                end
            end
            ISSUE: begin
                if (!br_busy) begin
                    if (write_reg) begin
                        state_next = WR_BEATS;
                        cnt_next   = CNT_W'(1);
                    end else begin
                        state_next = RD_COLLECT;
                        cnt_next   = '0;
                    end
                end
            end
            WR_BEATS: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_BEAT) begin
                    state_next = DONE;
                end
            end
            RD_COLLECT: begin
                if (beat_store) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (last_store) begin
                        state_next = DONE;
                    end
                end else if (timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // BurstRAM side outputs. Beat 0 rides on the command cycle; the remaining
    // beats follow back to back from the counter.
    always_comb begin
        wr_beat_active = (cmd_fire && write_reg) || (state_reg == WR_BEATS);
        beat_idx       = (state_reg == WR_BEATS) ? cnt_reg : '0;
        br_cmd_en      = cmd_fire;
        br_cmd         = cmd_fire && write_reg;
        br_addr        = cmd_fire ? {line_reg, {CNT_W{1'b0}}} : '0;
        br_wr_data     = '0;
        br_data_mask   = '1;
        if (wr_beat_active) begin
            br_wr_data   = wr_beat_reg[beat_idx];
            br_data_mask = wr_mask_reg[beat_idx];
        end
        rsp_valid = (state_reg == DONE);
    end

endmodule
